// File: rtl/cmd_interp_out_disp.sv
// Display end of the command-interpreter output register: converts the result
// byte to BCD with a shift-add-3 FSM and scans it onto a 4-digit 7-segment display.
module cmd_interp_out_disp #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       load,
  output logic       busy,
  output logic [3:0] an,
  output logic [7:0] seg
);

  typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [7:0]  shreg_r, shreg_s;
  logic [11:0] bcd_r, bcd_s, adj_s;
  logic [19:0] shift_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        busy_r, busy_s;
  logic [3:0]  units_r, units_s, tens_r, tens_s, hund_r, hund_s;

  logic [CNT_W-1:0] refresh_r;
  logic [1:0]       idx_r;
  logic             scan_valid_r;
  logic             wrap_s;
  logic [3:0]       an_r, an_s;
  logic [7:0]       seg_r, seg_s;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  // Conversion FSM: next state, datapath and display-register update
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    bcd_s   = bcd_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    units_s = units_r;
    tens_s  = tens_r;
    hund_s  = hund_r;
    adj_s   = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
    shift_s = {adj_s[10:0], shreg_r, 1'b0};
    case (state_r)
      IDLE: begin
        if (load) begin
          shreg_s = in;
          bcd_s   = 12'd0;
          cnt_s   = 4'd8;
          busy_s  = 1'b1;
          state_s = CONV;
        end else begin
          busy_s  = 1'b0;
        end
      end
      CONV: begin
        bcd_s   = shift_s[19:8];
        shreg_s = shift_s[7:0];
        cnt_s   = cnt_r - 4'd1;
        // The final shift lands straight in the display registers
        if (cnt_r == 4'd1) begin
          units_s = shift_s[11:8];
          tens_s  = shift_s[15:12];
          hund_s  = shift_s[19:16];
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          busy_s  = 1'b1;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Conversion state and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= 8'd0;
      bcd_r   <= 12'd0;
      cnt_r   <= 4'd0;
      busy_r  <= 1'b0;
      units_r <= 4'd0;
      tens_r  <= 4'd0;
      hund_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      bcd_r   <= bcd_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      units_r <= units_s;
      tens_r  <= tens_s;
      hund_r  <= hund_s;
    end
  end

  assign wrap_s = (refresh_r == CNT_W'(REFRESH_DIV - 1));

  // Refresh counter and digit index; the display stays dark until the first wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_r    <= '0;
      idx_r        <= 2'd0;
      scan_valid_r <= 1'b0;
    end else if (wrap_s) begin
      refresh_r    <= '0;
      idx_r        <= idx_r + 2'd1;
      scan_valid_r <= 1'b1;
    end else begin
      refresh_r    <= refresh_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Digit select and segment pattern with leading-zero blanking
  always_comb begin
    an_s  = 4'b1111;
    seg_s = 8'hFF;
    if (scan_valid_r) begin
      case (idx_r)
        2'd0: begin
          an_s  = 4'b1110;
          seg_s = seg_code(units_r);
        end
        2'd1: begin
          an_s  = 4'b1101;
          seg_s = ((hund_r == 4'd0) && (tens_r == 4'd0)) ? 8'hFF : seg_code(tens_r);
        end
        2'd2: begin
          an_s  = 4'b1011;
          seg_s = (hund_r == 4'd0) ? 8'hFF : seg_code(hund_r);
        end
        2'd3: begin
          an_s  = 4'b0111;
          seg_s = 8'hFF;
        end
        default: begin
          an_s  = 4'b1111;
          seg_s = 8'hFF;
        end
      endcase
    end else begin
      an_s  = 4'b1111;
      seg_s = 8'hFF;
    end
  end

  // Registered display pins
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= 4'b1111;
      seg_r <= 8'hFF;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign busy = busy_r;
  assign an   = an_r;
  assign seg  = seg_r;

endmodule

// File: tb/tb_cmd_interp_out_disp.sv
// Randomized bench for cmd_interp_out_disp against a cycle-count/decimal-arithmetic
// model, plus literal display checks for the directed cases.
module tb_cmd_interp_out_disp;
  localparam int DIV = 4;
  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst, load, busy;
  logic [7:0] in;
  logic [3:0] an;
  logic [7:0] seg;

  cmd_interp_out_disp #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in(in), .load(load), .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edges since reset, remaining conversion cycles, value on display
  bit         m_valid = 1'b0;
  int         m_n, m_rem, m_cap, m_disp;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;

  logic [7:0] cap_seg [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] view(input int slot, input int v);
    case (slot)
      0:       return {4'b1110, SEG_TAB[v % 10]};
      1:       return {4'b1101, (v < 10)  ? 8'hFF : SEG_TAB[(v / 10) % 10]};
      2:       return {4'b1011, (v < 100) ? 8'hFF : SEG_TAB[v / 100]};
      default: return {4'b0111, 8'hFF};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_n     = 0;
      m_rem   = 0;
      m_disp  = 0;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end else if (m_valid) begin
      if (m_n >= DIV) {exp_an, exp_seg} = view((m_n / DIV) % 4, m_disp);
      else begin
        exp_an  = 4'hF;
        exp_seg = 8'hFF;
      end
      m_n++;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_disp = m_cap;
      end else if (load) begin
        m_rem = 8;
        m_cap = int'(in);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("an", {28'd0, an}, {28'd0, exp_an});
      check("seg", {24'd0, seg}, {24'd0, exp_seg});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 30) begin
      k++;
      tick(1);
    end
    check("idle_timeout", {31'd0, (k >= 30)}, 32'd0);
  endtask

  task automatic load_measure(input logic [7:0] v, input string nm);
    int bc = 0;
    wait_idle();
    load = 1'b1;
    in   = v;
    tick(1);
    load = 1'b0;
    while (busy === 1'b1 && bc < 20) begin
      bc++;
      tick(1);
    end
    check({nm, " busy_len"}, bc, 32'd8);
  endtask

  task automatic capture();
    for (int i = 0; i < 4; i++) cap_seg[i] = 8'h00;
    repeat (5 * DIV + 2) begin
      tick(1);
      case (an)
        4'b1110: cap_seg[0] = seg;
        4'b1101: cap_seg[1] = seg;
        4'b1011: cap_seg[2] = seg;
        4'b0111: cap_seg[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_view(input string nm, input logic [7:0] u, input logic [7:0] t,
                            input logic [7:0] h);
    capture();
    check({nm, " units"}, {24'd0, cap_seg[0]}, {24'd0, u});
    check({nm, " tens"}, {24'd0, cap_seg[1]}, {24'd0, t});
    check({nm, " hundreds"}, {24'd0, cap_seg[2]}, {24'd0, h});
    check({nm, " blank3"}, {24'd0, cap_seg[3]}, 32'hFF);
  endtask

  initial begin
    logic [3:0] seq [4];
    logic [3:0] last;
    int k;
    rst  = 1'b1;
    load = 1'b0;
    in   = 8'd0;
    tick(2);
    rst = 1'b0;
    check("reset an", {28'd0, an}, 32'hF);
    check("reset seg", {24'd0, seg}, 32'hFF);
    check("reset busy", {31'd0, busy}, 32'd0);

    k = 0;
    last = 4'hF;
    for (int c = 0; c < 6 * DIV && k < 4; c++) begin
      tick(1);
      if (an != last && an != 4'hF) begin
        seq[k] = an;
        k++;
      end
      last = an;
    end
    check("scan order 0", {28'd0, seq[0]}, 32'hD);
    check("scan order 1", {28'd0, seq[1]}, 32'hB);
    check("scan order 2", {28'd0, seq[2]}, 32'h7);
    check("scan order 3", {28'd0, seq[3]}, 32'hE);
    check_view("reset", 8'hC0, 8'hFF, 8'hFF);

    load_measure(8'd173, "173");
    check_view("173", 8'hB0, 8'hF8, 8'hF9);
    load_measure(8'd255, "255");
    check_view("255", 8'h92, 8'h92, 8'hA4);
    load_measure(8'd7, "7");
    check_view("7", 8'hF8, 8'hFF, 8'hFF);
    load_measure(8'd40, "40");
    check_view("40", 8'hC0, 8'h99, 8'hFF);

    // load during conversion must be dropped
    wait_idle();
    load = 1'b1;
    in   = 8'd173;
    tick(1);
    load = 1'b0;
    tick(2);
    load = 1'b1;
    in   = 8'd9;
    tick(1);
    load = 1'b0;
    wait_idle();
    check_view("ignored load", 8'hB0, 8'hF8, 8'hF9);

    // reset during conversion aborts it and clears the display
    load_measure(8'd99, "99");
    load = 1'b1;
    in   = 8'd173;
    tick(1);
    load = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check_view("abort", 8'hC0, 8'hFF, 8'hFF);

    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom % 64) == 0;
      load = ($urandom % 4) == 0;
      in   = 8'($urandom);
      tick(1);
    end
    rst  = 1'b0;
    load = 1'b0;
    tick(2 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
